// File: rtl/stopwatch_pkg.sv
// Shared types and defaults for the stopwatch controller.
// Optional lap feature is selected in the top level by the STOPWATCH_LAP_EN macro.
package stopwatch_pkg;

  // Controller states; the encoding is visible on the state output.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int DEFAULT_CLK_HZ  = 100_000_000;
  localparam int DEFAULT_TICK_HZ = 100;

  // Clock cycles per count tick.
  function automatic int calc_div(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

endpackage

// File: rtl/stopwatch_rise_edge.sv
// Rising-edge detector for one debounced button level.
// Output is combinational from the live level and the registered previous level,
// so a press is acted on at the same edge that first samples it high.
module rise_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic i_level,
  output logic o_rise
);

  logic r_prev;

  // Remember last sampled level so a held button produces only one pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= i_level;
    end
  end

  assign o_rise = i_level & ~r_prev;

endmodule

// File: rtl/stopwatch_controller.sv
// Stopwatch controller: button handling, run/pause/done FSM, tick prescaler,
// counter load/enable generation and display latch.
// Macro STOPWATCH_LAP_EN enables the lap (display freeze) feature; when it is
// undefined btn_lap is ignored and lap_active is constant 0.
module stopwatch_controller
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ   = DEFAULT_CLK_HZ,
  parameter int TICK_HZ  = DEFAULT_TICK_HZ,
  parameter int NUM_BITS = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                btn_start_stop,
  input  logic                btn_clear,
  input  logic                btn_lap,
  input  logic                mode_down,
  input  logic [NUM_BITS-1:0] preset_value,
  input  logic [NUM_BITS-1:0] count_value,
  input  logic                count_zero,
  output logic                cnt_enable,
  output logic                cnt_up_down,
  output logic                cnt_set,
  output logic [NUM_BITS-1:0] cnt_set_value,
  output logic [NUM_BITS-1:0] disp_value,
  output logic                running,
  output logic                lap_active,
  output logic                alarm,
  output logic [1:0]          state
);

  localparam int DIV     = calc_div(CLK_HZ, TICK_HZ);
  localparam int PW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int NUM_BTN = 3;

  logic [1:0]          r_rst_sync;
  logic                w_hold;
  logic [NUM_BTN-1:0]  w_btn;
  logic [NUM_BTN-1:0]  w_rise;
  logic                w_ss;
  logic                w_clr;
  logic                w_lap;
  state_e              r_state;
  state_e              w_state_next;
  logic                w_clear_evt;
  logic                w_start_evt;
  logic                w_stay_run;
  logic                w_wrap;
  logic [PW-1:0]       r_presc;
  logic                r_cnt_enable;
  logic                r_up_down;
  logic                r_cnt_set;
  logic [NUM_BITS-1:0] r_set_value;
  logic [NUM_BITS-1:0] r_disp;
  logic                w_lap_active;

  // Two-flop release synchroniser; everything below stays in reset until it fills.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_hold = ~r_rst_sync[1];

  // One edge detector per button: bit 0 start/stop, bit 1 clear, bit 2 lap.
  assign w_btn = {btn_lap, btn_clear, btn_start_stop};

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BTN; gi++) begin : g_btn
      rise_edge u_rise (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_level (w_btn[gi]),
        .o_rise  (w_rise[gi])
      );
    end
  endgenerate

  assign w_ss  = w_rise[0] & ~w_hold;
  assign w_clr = w_rise[1] & ~w_hold;
  assign w_lap = w_rise[2] & ~w_hold;

  assign w_wrap = (r_presc == PW'(DIV - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else if (w_hold) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and per-cycle events; clear outranks every other cause.
  always_comb begin
    w_state_next = r_state;
    w_clear_evt  = 1'b0;
    w_start_evt  = 1'b0;
    w_stay_run   = 1'b0;
    if (w_clr) begin
      w_state_next = IDLE;
      w_clear_evt  = 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          // A countdown from zero would finish instantly, so refuse to start it.
          if (w_ss && !(mode_down && (preset_value == '0))) begin
            w_state_next = RUN;
            w_start_evt  = 1'b1;
          end
        end
        RUN: begin
          if (!r_up_down && count_zero) begin
            w_state_next = DONE;
          end else if (w_ss) begin
            w_state_next = PAUSE;
          end else begin
            w_stay_run = 1'b1;
          end
        end
        PAUSE: begin
          if (w_ss) begin
            w_state_next = RUN;
          end
        end
        DONE: begin
          w_state_next = DONE;
        end
        default: begin
          w_state_next = IDLE;
        end
      endcase
    end
  end

  // Prescaler: restarts on a fresh start, holds its phase through pause/done,
  // and only advances on cycles that stay in RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
    end else if (w_hold) begin
      r_presc <= '0;
    end else if (w_start_evt) begin
      r_presc <= '0;
    end else if (w_stay_run) begin
      r_presc <= w_wrap ? '0 : r_presc + PW'(1);
    end
  end

  // Count-tick pulse on the prescaler wrap; never issued on the cycle that ends a countdown.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt_enable <= 1'b0;
    end else if (w_hold) begin
      r_cnt_enable <= 1'b0;
    end else begin
      r_cnt_enable <= w_stay_run & w_wrap;
    end
  end

  // Direction follows the switch while idle and is frozen once a run starts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_up_down <= 1'b1;
    end else if (w_hold) begin
      r_up_down <= 1'b1;
    end else if (r_state == IDLE) begin
      r_up_down <= ~mode_down;
    end
  end

  // Counter load on clear: preset for countdown, zero for count-up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt_set   <= 1'b0;
      r_set_value <= '0;
    end else if (w_hold) begin
      r_cnt_set   <= 1'b0;
      r_set_value <= '0;
    end else begin
      r_cnt_set <= w_clear_evt;
      if (w_clear_evt) begin
        r_set_value <= mode_down ? preset_value : '0;
      end
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic r_lap_active;

  // Lap toggle while running or paused; clear and countdown completion drop it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lap_active <= 1'b0;
    end else if (w_hold) begin
      r_lap_active <= 1'b0;
    end else if (w_clear_evt || (w_state_next == DONE)) begin
      r_lap_active <= 1'b0;
    end else if (w_lap && ((r_state == RUN) || (r_state == PAUSE))) begin
      r_lap_active <= ~r_lap_active;
    end
  end

  assign w_lap_active = r_lap_active;
`else
  // Lap button is deliberately without effect in this build.
  assign w_lap_active = w_lap & 1'b0;
`endif

  // Display copy of the counter; the edge that sets lap captures, later edges freeze.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_disp <= '0;
    end else if (w_hold) begin
      r_disp <= '0;
    end else if (!w_lap_active) begin
      r_disp <= count_value;
    end
  end

  assign cnt_enable    = r_cnt_enable;
  assign cnt_up_down   = r_up_down;
  assign cnt_set       = r_cnt_set;
  assign cnt_set_value = r_set_value;
  assign disp_value    = r_disp;
  assign running       = (r_state == RUN);
  assign alarm         = (r_state == DONE);
  assign lap_active    = w_lap_active;
  assign state         = r_state;

endmodule

// File: tb/tb_stopwatch_controller.sv
// Self-checking bench for stopwatch_controller (CLK_HZ=100, TICK_HZ=10 -> 10 cycles per tick).
// Directed scenarios use timing constants; a random phase is checked every cycle
// against a behavioural model. The bench also plays the external counter.
module tb_stopwatch_controller;

  localparam int CLK_HZ  = 100;
  localparam int TICK_HZ = 10;
  localparam int DIV     = CLK_HZ / TICK_HZ;
  localparam int NB      = 16;
`ifdef STOPWATCH_LAP_EN
  localparam bit LAP_EN  = 1'b1;
`else
  localparam bit LAP_EN  = 1'b0;
`endif
  localparam int S_IDLE  = 0;
  localparam int S_RUN   = 1;
  localparam int S_PAUSE = 2;
  localparam int S_DONE  = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          btn_start_stop = 1'b0;
  logic          btn_clear = 1'b0;
  logic          btn_lap = 1'b0;
  logic          mode_down = 1'b0;
  logic [NB-1:0] preset_value = '0;
  logic [NB-1:0] count_value = '0;
  logic          count_zero;
  logic          cnt_enable;
  logic          cnt_up_down;
  logic          cnt_set;
  logic [NB-1:0] cnt_set_value;
  logic [NB-1:0] disp_value;
  logic          running;
  logic          lap_active;
  logic          alarm;
  logic [1:0]    state;

  int checks = 0;
  int errors = 0;

  stopwatch_controller #(
    .CLK_HZ   (CLK_HZ),
    .TICK_HZ  (TICK_HZ),
    .NUM_BITS (NB)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .btn_start_stop (btn_start_stop),
    .btn_clear      (btn_clear),
    .btn_lap        (btn_lap),
    .mode_down      (mode_down),
    .preset_value   (preset_value),
    .count_value    (count_value),
    .count_zero     (count_zero),
    .cnt_enable     (cnt_enable),
    .cnt_up_down    (cnt_up_down),
    .cnt_set        (cnt_set),
    .cnt_set_value  (cnt_set_value),
    .disp_value     (disp_value),
    .running        (running),
    .lap_active     (lap_active),
    .alarm          (alarm),
    .state          (state)
  );

  always #5 clk = ~clk;

  // External up/down counter driven by the controller's outputs.
  assign count_zero = (count_value == '0);
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_value <= '0;
    else if (cnt_set) count_value <= cnt_set_value;
    else if (cnt_enable) count_value <= cnt_up_down ? count_value + 16'd1 : count_value - 16'd1;
  end

  // ---------------- behavioural reference model ----------------
  int            m_state, m_phase, m_hold;
  bit            m_updn, m_en, m_set, m_lap;
  logic [NB-1:0] m_setval, m_disp;
  bit            p_ss, p_clr, p_lap, e_ss, e_clr, e_lap;

  task automatic model_cycle();
    int old;
    old = m_state;
    m_en = 1'b0;
    m_set = 1'b0;
    if (!m_lap) m_disp = count_value;
    if (old == S_IDLE) m_updn = !mode_down;
    if (e_clr) begin
      m_state = S_IDLE;
      m_set = 1'b1;
      m_setval = mode_down ? preset_value : '0;
      m_lap = 1'b0;
    end else begin
      case (old)
        S_IDLE: if (e_ss && !(mode_down && preset_value == 0)) begin
          m_state = S_RUN;
          m_phase = 0;
        end
        S_RUN: begin
          if (!m_updn && count_value == 0) begin
            m_state = S_DONE;
            m_lap = 1'b0;
          end else begin
            if (e_ss) m_state = S_PAUSE;
            else begin
              m_phase = m_phase + 1;
              if (m_phase == DIV) begin
                m_phase = 0;
                m_en = 1'b1;
              end
            end
            if (LAP_EN && e_lap) m_lap = !m_lap;
          end
        end
        S_PAUSE: begin
          if (e_ss) m_state = S_RUN;
          if (LAP_EN && e_lap) m_lap = !m_lap;
        end
        default: ;
      endcase
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state = S_IDLE; m_phase = 0; m_hold = 2;
      m_updn = 1'b1; m_en = 1'b0; m_set = 1'b0; m_lap = 1'b0;
      m_setval = '0; m_disp = '0;
      p_ss = 1'b0; p_clr = 1'b0; p_lap = 1'b0;
    end else begin
      e_ss  = btn_start_stop && !p_ss;
      e_clr = btn_clear && !p_clr;
      e_lap = btn_lap && !p_lap;
      p_ss  = btn_start_stop;
      p_clr = btn_clear;
      p_lap = btn_lap;
      if (m_hold > 0) m_hold = m_hold - 1;
      else model_cycle();
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clear();
    btn_clear = 1'b1;
    tick();
    btn_clear = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if (state !== 2'd0 || cnt_up_down !== 1'b1) begin
      errors++;
      $display("FAIL reset_async: state=%0d up_down=%0b want 0/1", state, cnt_up_down);
    end
    repeat (3) tick();
    checks++;
    if ({cnt_enable, cnt_set, running, alarm, lap_active} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b want 00000", {cnt_enable, cnt_set, running, alarm, lap_active});
    end
    checks++;
    if (disp_value !== 16'h0 || cnt_set_value !== 16'h0) begin
      errors++;
      $display("FAIL reset_data: disp=%h setval=%h want 0/0", disp_value, cnt_set_value);
    end
    // A press in the first cycle after release falls inside the synchroniser window.
    rst_n = 1'b1;
    btn_start_stop = 1'b1;
    tick();
    btn_start_stop = 1'b0;
    repeat (3) tick();
    checks++;
    if (state !== 2'd0) begin
      errors++;
      $display("FAIL reset_sync_window: state=%0d want 0", state);
    end
  endtask

  task automatic test_start_timing();
    int first, pulses;
    bit last;
    mode_down = 1'b0;
    btn_start_stop = 1'b1;
    tick();
    btn_start_stop = 1'b0;
    checks++;
    if (state !== 2'd1 || running !== 1'b1) begin
      errors++;
      $display("FAIL start_latency: state=%0d running=%0b want 1/1", state, running);
    end
    first = 0;
    for (int i = 1; i <= 30 && first == 0; i++) begin
      tick();
      if (cnt_enable) first = i;
    end
    checks++;
    if (first != 10) begin
      errors++;
      $display("FAIL first_tick: after %0d cycles want 10", first);
    end
    pulses = 0;
    last = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (cnt_enable) pulses++;
      last = cnt_enable;
    end
    checks++;
    if (pulses != 1 || !last) begin
      errors++;
      $display("FAIL tick_period: pulses=%0d on_10th=%0b want 1/1", pulses, last);
    end
  endtask

  task automatic test_pause_resume();
    int pulses, gap;
    bool_state_loop: begin end
    repeat (4) tick();
    btn_start_stop = 1'b1;
    repeat (3) tick();
    btn_start_stop = 1'b0;
    checks++;
    if (state !== 2'd2) begin
      errors++;
      $display("FAIL pause_enter: state=%0d want 2", state);
    end
    pulses = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (cnt_enable || state !== 2'd2) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL pause_hold: %0d bad cycles want 0", pulses);
    end
    btn_start_stop = 1'b1;
    tick();
    btn_start_stop = 1'b0;
    gap = 0;
    for (int i = 1; i <= 30 && gap == 0; i++) begin
      tick();
      if (cnt_enable) gap = i;
    end
    checks++;
    if (gap != 6) begin
      errors++;
      $display("FAIL resume_phase: pulse after %0d cycles want 6", gap);
    end
  endtask

  task automatic test_countdown_done();
    int pulses;
    mode_down = 1'b1;
    preset_value = 16'h0003;
    pulse_clear();
    checks++;
    if (state !== 2'd0 || cnt_set !== 1'b1 || cnt_set_value !== 16'h0003) begin
      errors++;
      $display("FAIL clear_load: state=%0d set=%0b val=%h want 0/1/0003", state, cnt_set, cnt_set_value);
    end
    tick();
    btn_start_stop = 1'b1;
    tick();
    btn_start_stop = 1'b0;
    pulses = 0;
    for (int i = 0; i < 45; i++) begin
      tick();
      if (cnt_enable) pulses++;
    end
    checks++;
    if (pulses != 3 || state !== 2'd3 || alarm !== 1'b1) begin
      errors++;
      $display("FAIL countdown: pulses=%0d state=%0d alarm=%0b want 3/3/1", pulses, state, alarm);
    end
    btn_start_stop = 1'b1;
    btn_lap = 1'b1;
    tick();
    btn_start_stop = 1'b0;
    btn_lap = 1'b0;
    tick();
    checks++;
    if (state !== 2'd3 || lap_active !== 1'b0) begin
      errors++;
      $display("FAIL done_ignore: state=%0d lap=%0b want 3/0", state, lap_active);
    end
    pulse_clear();
    checks++;
    if (state !== 2'd0 || alarm !== 1'b0 || cnt_set !== 1'b1) begin
      errors++;
      $display("FAIL done_clear: state=%0d alarm=%0b set=%0b want 0/0/1", state, alarm, cnt_set);
    end
  endtask

  task automatic test_clear_wins();
    mode_down = 1'b0;
    tick();
    btn_start_stop = 1'b1;
    tick();
    btn_start_stop = 1'b0;
    repeat (7) tick();
    btn_start_stop = 1'b1;
    btn_clear = 1'b1;
    tick();
    btn_start_stop = 1'b0;
    btn_clear = 1'b0;
    checks++;
    if (state !== 2'd0 || cnt_set !== 1'b1 || cnt_set_value !== 16'h0) begin
      errors++;
      $display("FAIL clear_wins: state=%0d set=%0b val=%h want 0/1/0000", state, cnt_set, cnt_set_value);
    end
    tick();
    checks++;
    if (cnt_set !== 1'b0 || state !== 2'd0) begin
      errors++;
      $display("FAIL set_one_cycle: set=%0b state=%0d want 0/0", cnt_set, state);
    end
  endtask

  task automatic test_preset_zero();
    mode_down = 1'b1;
    preset_value = 16'h0000;
    tick();
    btn_start_stop = 1'b1;
    tick();
    btn_start_stop = 1'b0;
    tick();
    checks++;
    if (state !== 2'd0) begin
      errors++;
      $display("FAIL preset_zero: state=%0d want 0", state);
    end
  endtask

  task automatic test_mode_hold();
    mode_down = 1'b0;
    tick();
    btn_start_stop = 1'b1;
    tick();
    btn_start_stop = 1'b0;
    mode_down = 1'b1;
    repeat (3) tick();
    checks++;
    if (cnt_up_down !== 1'b1 || state !== 2'd1) begin
      errors++;
      $display("FAIL mode_hold: up_down=%0b state=%0d want 1/1", cnt_up_down, state);
    end
    pulse_clear();
  endtask

  task automatic test_lap();
    mode_down = 1'b1;
    preset_value = 16'h0042;
    tick();
    pulse_clear();
    tick();
    mode_down = 1'b0;
    tick();
    btn_start_stop = 1'b1;
    tick();
    btn_start_stop = 1'b0;
    btn_lap = 1'b1;
    tick();
    btn_lap = 1'b0;
    repeat (25) tick();
`ifdef STOPWATCH_LAP_EN
    checks++;
    if (lap_active !== 1'b1 || disp_value !== 16'h0042 || count_value !== 16'h0044) begin
      errors++;
      $display("FAIL lap_freeze: lap=%0b disp=%h count=%h want 1/0042/0044", lap_active, disp_value, count_value);
    end
`else
    checks++;
    if (lap_active !== 1'b0 || disp_value !== 16'h0044) begin
      errors++;
      $display("FAIL lap_ignored: lap=%0b disp=%h want 0/0044", lap_active, disp_value);
    end
`endif
    btn_lap = 1'b1;
    tick();
    btn_lap = 1'b0;
    repeat (3) tick();
    checks++;
    if (lap_active !== 1'b0 || disp_value !== 16'h0044) begin
      errors++;
      $display("FAIL lap_release: lap=%0b disp=%h want 0/0044", lap_active, disp_value);
    end
    pulse_clear();
  endtask

  task automatic test_random();
    logic [7:0]    exp_ctrl, got_ctrl;
    int            e0;
    e0 = errors;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) btn_start_stop = ~btn_start_stop;
      if ($urandom_range(0, 60) == 0) btn_clear = ~btn_clear;
      if ($urandom_range(0, 15) == 0) btn_lap = ~btn_lap;
      if ($urandom_range(0, 100) == 0) mode_down = ~mode_down;
      if ($urandom_range(0, 200) == 0) preset_value = NB'($urandom_range(0, 4));
      tick();
      exp_ctrl = {2'(m_state), m_state == S_RUN, m_state == S_DONE, m_updn, m_en, m_set, m_lap};
      got_ctrl = {state, running, alarm, cnt_up_down, cnt_enable, cnt_set, lap_active};
      checks++;
      if (got_ctrl !== exp_ctrl) begin
        errors++;
        $display("FAIL rand_ctrl cycle %0d: got %b want %b", i, got_ctrl, exp_ctrl);
      end
      checks++;
      if (disp_value !== m_disp || cnt_set_value !== m_setval) begin
        errors++;
        $display("FAIL rand_data cycle %0d: disp=%h setval=%h want %h/%h", i, disp_value, cnt_set_value, m_disp, m_setval);
      end
      if (errors != e0) break;
    end
    btn_start_stop = 1'b0;
    btn_clear = 1'b0;
    btn_lap = 1'b0;
    repeat (2) tick();
    pulse_clear();
    mode_down = 1'b0;
    tick();
  endtask

  task automatic test_reset_midrun();
    int pulses;
    btn_start_stop = 1'b1;
    tick();
    btn_start_stop = 1'b0;
    repeat (12) tick();
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({state, running, alarm, cnt_enable, cnt_set, lap_active} !== 7'b0 ||
        disp_value !== 16'h0 || cnt_set_value !== 16'h0 || cnt_up_down !== 1'b1) begin
      errors++;
      $display("FAIL midrun_reset: state=%0d run=%0b en=%0b disp=%h setval=%h up=%0b want all 0, up=1",
               state, running, cnt_enable, disp_value, cnt_set_value, cnt_up_down);
    end
    tick();
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (cnt_enable || state !== 2'd0) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL after_reset_idle: %0d bad cycles want 0", pulses);
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_start_timing();
    test_pause_resume();
    test_countdown_done();
    test_clear_wins();
    test_preset_zero();
    test_mode_hold();
    test_lap();
    test_random();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stopwatch_controller.md
STOPWATCH_CONTROLLER -- requirements
Module: stopwatch_controller

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100_000_000: board clock frequency.
REQ-002 SHALL have parameter TICK_HZ, default 100: count-tick rate; divider DIV = CLK_HZ/TICK_HZ, and DIV >= 2.
REQ-003 SHALL have parameter NUM_BITS, default 16: counter value width (4 BCD digits x 4 bits).
REQ-004 SHALL have ports, clock and reset first:
- clk  in  1  single system clock, rising edge; one clock only.
- rst_n  in  1  reset, asynchronous assert, active-low.
- btn_start_stop  in  1  debounced level.
- btn_clear  in  1  debounced level.
- btn_lap  in  1  debounced level.
- mode_down  in  1  switch level; 1 = countdown.
- preset_value  in  NUM_BITS  countdown start value.
- count_value  in  NUM_BITS  current counter value.
- count_zero  in  1  counter value equals 0.
- cnt_enable  out  1  one-cycle count-tick pulse.
- cnt_up_down  out  1  1 = count up.
- cnt_set  out  1  one-cycle load pulse.
- cnt_set_value  out  NUM_BITS  load data.
- disp_value  out  NUM_BITS  value for the display driver.
- running  out  1.
- lap_active  out  1.
- alarm  out  1.
- state  out  2  FSM state.

Function
REQ-005 SHALL detect rising edges of all three buttons; a button action SHALL take effect on the next clock edge after the rising edge is sampled (latency 1); held buttons SHALL NOT repeat.
REQ-006 SHALL implement FSM IDLE=0, RUN=1, PAUSE=2, DONE=3.
REQ-007 IDLE: on start_stop, go to RUN, latch cnt_up_down = ~mode_down, and clear the prescaler; if mode_down=1 and preset_value=0, SHALL ignore the press.
REQ-008 RUN: start_stop goes to PAUSE; clear goes to IDLE.
REQ-009 PAUSE: start_stop goes to RUN and the prescaler SHALL resume from its held phase; clear goes to IDLE.
REQ-010 DONE: SHALL assert alarm; start_stop and lap are ignored; clear goes to IDLE and alarm deasserts.
REQ-011 When start_stop and clear are pressed in the same cycle, clear SHALL win.
REQ-012 Prescaler SHALL count 0..DIV-1, advance only in RUN, and wrap to 0; cnt_enable=1 for exactly the one cycle in which it wraps.
REQ-013 In RUN with cnt_up_down=0 and count_zero=1, SHALL go to DONE; cnt_enable SHALL be suppressed that cycle (no underflow past 0).
REQ-014 Up-count wrap past all-nines is the counter's behaviour; the controller SHALL NOT stop on it.
REQ-015 Every transition into IDLE caused by clear SHALL pulse cnt_set for one cycle, with cnt_set_value = preset_value if mode_down=1, else 0.
REQ-016 In IDLE, cnt_up_down SHALL track ~mode_down; in all other states it SHALL hold its latched value, and changes to mode_down SHALL be ignored.
REQ-017 running SHALL equal (state==RUN).
REQ-018 disp_value SHALL be a registered copy of count_value (1-cycle latency) unless lap_active=1.

Reset
REQ-019 rst_n low SHALL immediately force state=IDLE, prescaler=0, lap_active=0, and every output to 0, with cnt_up_down=1; this applies mid-operation.
REQ-020 Release of rst_n SHALL be synchronised internally (two-flop) before the FSM leaves reset.

Configuration
REQ-021 Macro STOPWATCH_LAP_EN defined: in RUN or PAUSE, a lap edge SHALL toggle lap_active.
- Setting lap_active SHALL capture count_value into disp_value and freeze it.
- Clearing lap_active SHALL return disp_value to tracking.
- clear or entry to DONE SHALL force lap_active=0.
REQ-022 Macro STOPWATCH_LAP_EN undefined: btn_lap SHALL be present but ignored, lap_active SHALL be tied 0, and disp_value SHALL always track.

Structure
REQ-023 Package stopwatch_pkg SHALL hold the state enum (IDLE/RUN/PAUSE/DONE) and the default CLK_HZ/TICK_HZ constants.
REQ-024 SHALL use one sub-module, rise_edge, instantiated per button: registered previous level; output = in & ~prev.

Verification (CLK_HZ=100, TICK_HZ=10, DIV=10)
REQ-025 Reset, then start_stop at cycle 5 -> state=RUN at cycle 6; cnt_enable pulses every 10 cycles, first at cycle 16.
REQ-026 RUN, start_stop at prescaler=4, wait 50 cycles, start_stop -> PAUSE with no pulses; after resume, next pulse arrives 6 cycles later.
REQ-027 mode_down=1, preset=16'h0003, clear then start, count_zero driven after 3 ticks -> DONE, alarm=1, no 4th cnt_enable.
REQ-028 start_stop and clear in same cycle while in RUN -> IDLE, one cnt_set pulse, cnt_set_value=0 (mode up).
REQ-029 With STOPWATCH_LAP_EN defined, lap at count 16'h0042 -> disp_value holds 0042 while count advances; second lap -> tracking resumes. Without the macro, lap has no effect.
REQ-030 rst_n pulsed low mid-RUN -> all outputs 0 asynchronously; no cnt_enable until a new start_stop.
